// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between cache refills and
// write-buffer drains, favouring refills but bounding how long a drain can be deferred.
module mem_port_arbiter #(
    parameter int LATENCY   = 4,
    parameter int MAX_DEFER = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic        wb_req,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        rd_done,
    output logic [31:0] rd_data,
    output logic        wb_done,
    output logic        stall_rd,
    output logic        stall_wb,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_cnt, r_defer;
    logic [31:0] r_addr, r_wdata;
    logic        w_last, w_arb, w_gnt_rd, w_gnt_wb;
    always_comb begin
        w_last   = r_state != IDLE && r_cnt == 4'(LATENCY - 1);
        w_arb    = r_state == IDLE || w_last;
        // a waiting write wins only once reads have used up their deferral budget
        w_gnt_rd = w_arb && rd_req && !(wb_req && r_defer == 4'(MAX_DEFER));
        w_gnt_wb = w_arb && wb_req && !w_gnt_rd;
        w_next   = w_gnt_rd ? READ : w_gnt_wb ? WRITE : w_arb ? IDLE : r_state;
        mem_en   = r_state != IDLE;
        mem_we   = r_state == WRITE;
        busy     = r_state != IDLE;
        rd_done  = r_state == READ && w_last;
        wb_done  = r_state == WRITE && w_last;
        rd_data  = rd_done ? mem_rdata : '0;
        stall_rd = rd_req & ~rd_done;
        stall_wb = wb_req & ~wb_done;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_defer <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_cnt <= w_arb ? 4'd0 : r_cnt + 4'd1;
            if (w_gnt_rd || w_gnt_wb) r_addr <= w_gnt_rd ? rd_addr : wb_addr;
            if (w_gnt_wb) begin
                r_wdata <= wb_data;
                r_defer <= '0;
            end else if (w_gnt_rd && wb_req && r_defer != 4'(MAX_DEFER)) begin
                r_defer <= r_defer + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed steps with a scoreboard of expected completions,
// plus a LATENCY=2 instance for back-to-back refill timing.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, rd_req, wb_req, mem_en, mem_we, rd_done, wb_done, stall_rd, stall_wb, busy;
    logic [31:0] rd_addr, wb_addr, wb_data, mem_rdata, mem_addr, mem_wdata, rd_data;
    logic        b_rd_req, b_wb_req, b_mem_en, b_mem_we, b_rd_done, b_wb_done, b_stall_rd, b_stall_wb, b_busy;
    logic [31:0] b_rd_addr, b_wb_addr, b_wb_data, b_mem_rdata, b_mem_addr, b_mem_wdata, b_rd_data;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : a ^ 32'hA5A5_A5A5;
    endfunction
    assign mem_rdata   = mem_model(mem_addr);
    assign b_mem_rdata = mem_model(b_mem_addr);

    mem_port_arbiter #(.LATENCY(4), .MAX_DEFER(2)) u_dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .wb_req(wb_req),
        .wb_addr(wb_addr), .wb_data(wb_data), .mem_rdata(mem_rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rd_done(rd_done),
        .rd_data(rd_data), .wb_done(wb_done), .stall_rd(stall_rd), .stall_wb(stall_wb), .busy(busy));

    mem_port_arbiter #(.LATENCY(2), .MAX_DEFER(2)) u_dut2 (
        .clk(clk), .reset(reset), .rd_req(b_rd_req), .rd_addr(b_rd_addr), .wb_req(b_wb_req),
        .wb_addr(b_wb_addr), .wb_data(b_wb_data), .mem_rdata(b_mem_rdata), .mem_en(b_mem_en),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .rd_done(b_rd_done),
        .rd_data(b_rd_data), .wb_done(b_wb_done), .stall_rd(b_stall_rd), .stall_wb(b_stall_wb), .busy(b_busy));

    typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} exp_t;
    exp_t q[$];
    int errors = 0, checks = 0;
    logic auto_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        q.push_back(e);
    endtask

    // advance to the middle of the next cycle and retire any completion against the scoreboard
    task automatic cyc();
        @(negedge clk);
        if (rd_done || wb_done) begin
            chk("both_done", {31'b0, rd_done & wb_done}, 32'd0);
            if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_kind", {31'b0, wb_done}, {31'b0, e.wr});
                chk("sb_addr", mem_addr, e.addr);
                chk("sb_data", wb_done ? mem_wdata : rd_data, e.data);
            end
            if (auto_drop) begin
                if (rd_done) rd_req = 1'b0;
                if (wb_done) wb_req = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b0; auto_drop = 1'b1;
        rd_req = 0; wb_req = 0; rd_addr = 0; wb_addr = 0; wb_data = 0;
        b_rd_req = 0; b_wb_req = 0; b_rd_addr = 0; b_wb_addr = 0; b_wb_data = 0;
        #2;
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {30'b0, rd_done, wb_done}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk); reset = 1'b1;
        cyc(); cyc();
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // single read, with the refill address changing mid-access
        rd_req = 1'b1; rd_addr = 32'h100;
        push(1'b0, 32'h100, 32'hDEADBEEF);
        #1 chk("rd_c0_stall", {31'b0, stall_rd}, 32'd1);
        chk("rd_c0_mem_en", {31'b0, mem_en}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("rd_mem_en", {31'b0, mem_en}, 32'd1);
            chk("rd_mem_we", {31'b0, mem_we}, 32'd0);
            chk("rd_busy", {31'b0, busy}, 32'd1);
            chk("rd_mem_addr", mem_addr, 32'h100);
            chk("rd_done_timing", {31'b0, rd_done}, {31'b0, k == 4});
            chk("rd_stall", {31'b0, stall_rd}, {31'b0, k < 4});
            if (k == 2) rd_addr = 32'h200;
        end
        cyc();
        chk("rd_after_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rd_after_busy", {31'b0, busy}, 32'd0);

        // single write, with the head data changing mid-access
        wb_req = 1'b1; wb_addr = 32'h40; wb_data = 32'h12345678;
        push(1'b1, 32'h40, 32'h12345678);
        #1 chk("wb_c0_stall", {31'b0, stall_wb}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("wb_mem_we", {31'b0, mem_we}, 32'd1);
            chk("wb_mem_addr", mem_addr, 32'h40);
            chk("wb_mem_wdata", mem_wdata, 32'h12345678);
            chk("wb_done_timing", {31'b0, wb_done}, {31'b0, k == 4});
            if (k == 2) wb_data = 32'hFFFF0000;
        end
        cyc();
        chk("wb_after_mem_en", {31'b0, mem_en}, 32'd0);

        // both requests held: READ, READ, WRITE, READ, READ, WRITE with no gaps
        auto_drop = 1'b0;
        rd_req = 1'b1; rd_addr = 32'h300; wb_req = 1'b1; wb_addr = 32'h80; wb_data = 32'hCAFE0001;
        for (int g = 0; g < 6; g++)
            if (g % 3 == 2) push(1'b1, 32'h80, 32'hCAFE0001);
            else            push(1'b0, 32'h300, 32'h300 ^ 32'hA5A5_A5A5);
        for (int k = 1; k <= 24; k++) begin
            cyc();
            chk("starve_no_idle", {31'b0, mem_en}, 32'd1);
        end
        rd_req = 1'b0; wb_req = 1'b0;
        chk("starve_sb_empty", q.size(), 32'd0);
        cyc();
        chk("starve_after_idle", {31'b0, mem_en}, 32'd0);

        // reset in cycle 2 of a write aborts it; the write restarts after release
        auto_drop = 1'b1;
        wb_req = 1'b1; wb_addr = 32'h44; wb_data = 32'h55AA55AA;
        cyc(); cyc();
        #2 reset = 1'b0;
        #1 chk("arst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        cyc();
        chk("arst_no_done", {31'b0, wb_done}, 32'd0);
        chk("arst_held_idle", {31'b0, mem_en}, 32'd0);
        reset = 1'b1;
        push(1'b1, 32'h44, 32'h55AA55AA);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("rewb_mem_we", {31'b0, mem_we}, 32'd1);
            chk("rewb_done_timing", {31'b0, wb_done}, {31'b0, k == 4});
        end
        cyc();
        chk("rewb_after_mem_en", {31'b0, mem_en}, 32'd0);
        chk("sb_empty", q.size(), 32'd0);

        // LATENCY=2 instance: held refill request completes every second cycle
        b_rd_req = 1'b1; b_rd_addr = 32'h500;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("l2_mem_en", {31'b0, b_mem_en}, 32'd1);
            chk("l2_rd_done", {31'b0, b_rd_done}, {31'b0, k % 2 == 0});
            if (k % 2 == 0) chk("l2_rd_data", b_rd_data, 32'hA5A5A0A5);
        end
        b_rd_req = 1'b0;
        cyc(); cyc();
        chk("l2_idle", {31'b0, b_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
